multicycle_ctrl: RTL and testbench

- Main sequencing FSM for the multi-cycle RV32I dCPU core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Handshakes with instruction and data memory; gates register-file and PC writes using the instruction decoder's flags.
- Sits between the decoder, ALU, register file, PC register and the two memory ports; owns no datapath itself.

---
 rtl/multicycle_ctrl_pkg.sv | 32 +++
 rtl/ctrl_perf_counter.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencing controller.
// Provides the FSM state type, the raw state codes (for debug decoders and
// benches that only see the 3-bit state port) and a small state classifier.
package multicycle_ctrl_pkg;

  // Raw state codes as seen on the debug state port.
  localparam logic [2:0] CTRL_IDLE   = 3'd0;
  localparam logic [2:0] CTRL_FETCH  = 3'd1;
  localparam logic [2:0] CTRL_DECODE = 3'd2;
  localparam logic [2:0] CTRL_EXEC   = 3'd3;
  localparam logic [2:0] CTRL_MEM    = 3'd4;
  localparam logic [2:0] CTRL_WB     = 3'd5;
  localparam logic [2:0] CTRL_HALT   = 3'd6;
  localparam logic [2:0] CTRL_TRAP   = 3'd7;

  typedef enum logic [2:0] {
    StIdle   = CTRL_IDLE,
    StFetch  = CTRL_FETCH,
    StDecode = CTRL_DECODE,
    StExec   = CTRL_EXEC,
    StMem    = CTRL_MEM,
    StWb     = CTRL_WB,
    StHalt   = CTRL_HALT,
    StTrap   = CTRL_TRAP
  } ctrl_state_e;

  // True while an instruction is being processed (not idle or stopped).
  function automatic logic ctrl_is_running(ctrl_state_e s);
    return (s != StIdle) && (s != StHalt) && (s != StTrap);
  endfunction

endpackage

// File: rtl/ctrl_perf_counter.sv
// Performance counters for the multi-cycle controller.
// Only built when CTRL_PERF_CNT_EN is defined.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   count_cycle     increment cycle_cnt this cycle
//   count_instret   increment instret_cnt this cycle (one per retired instr)
//   cycle_cnt       active-cycle count, wraps modulo 2^32
//   instret_cnt     retired-instruction count, wraps modulo 2^32
`ifdef CTRL_PERF_CNT_EN
module ctrl_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_cycle,
  input  logic        count_instret,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (count_cycle) begin
      cycle_d = cycle_q + 32'd1;
    end
    if (count_instret) begin
      instret_d = instret_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule
`endif

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, (MEM,) WB, handshakes
// with the instruction and data memories and gates IR/EX/RF/PC write strobes.
// Owns no datapath.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   is_load, is_store      decoder flags (valid from DECODE onward)
//   reg_we, is_halt        decoder register-write and halt flags
//   dec_illegal            decoder did not recognise the opcode
//   imem_ack, dmem_ack     single-cycle memory acknowledges
//   imem_req, dmem_req     level memory requests; dmem_we qualifies dmem_req
//   ir_we, ex_we           latch IR / latch ALU result
//   rf_we, pc_we           register-file / PC write strobes
//   halted, trap           sticky stop indications
//   state                  current FSM state (debug)
//   cycle_cnt, instret_cnt performance counters (only with CTRL_PERF_CNT_EN)
//
// Parameters:
//   MEM_TIMEOUT  wait cycles tolerated on a memory request before trapping;
//                0 disables the watchdog
//   CNT_W        watchdog counter width, must hold MEM_TIMEOUT
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        reg_we,
  input  logic        is_halt,
  input  logic        dec_illegal,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        ex_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halted,
  output logic        trap,
  output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam bit WdEnable = (MEM_TIMEOUT != 0);
  // Trap fires on the wait cycle whose increment would reach MEM_TIMEOUT.
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;

  // Outputs decode from state_q only, so the async reset drops any
  // outstanding request in the same cycle.
  always_comb begin
    state_d  = state_q;
    wd_d     = '0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    ex_we    = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    halted   = 1'b0;
    trap     = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (WdEnable && (wd_q == WdLast)) begin
          state_d = StTrap;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end
      StDecode: begin
        if (dec_illegal) begin
          state_d = StTrap;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        ex_we   = 1'b1;
        state_d = (is_load || is_store) ? StMem : StWb;
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          state_d = StWb;
        end else if (WdEnable && (wd_q == WdLast)) begin
          state_d = StTrap;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end
      StWb: begin
        rf_we   = reg_we;
        pc_we   = 1'b1;
        state_d = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
      end
      StTrap: begin
        trap = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
  ctrl_perf_counter u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .count_cycle  (ctrl_is_running(state_q)),
    .count_instret(state_q == StWb),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl (MEM_TIMEOUT = 4). The driver
// pushes the expected per-cycle output vector as it drives each cycle;
// a monitor on the falling edge pops and compares.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam logic [8:0] IREQ = 9'h100;
  localparam logic [8:0] DREQ = 9'h080;
  localparam logic [8:0] DWE  = 9'h040;
  localparam logic [8:0] IRWE = 9'h020;
  localparam logic [8:0] EXWE = 9'h010;
  localparam logic [8:0] RFWE = 9'h008;
  localparam logic [8:0] PCWE = 9'h004;
  localparam logic [8:0] HLT  = 9'h002;
  localparam logic [8:0] TRP  = 9'h001;
  localparam logic [8:0] NONE = 9'h000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic is_load = 1'b0, is_store = 1'b0, reg_we = 1'b0, is_halt = 1'b0;
  logic dec_illegal = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, ex_we, rf_we, pc_we, halted, trap;
  logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
  logic [31:0] m_cyc = '0, m_ret = '0;
`endif

  typedef struct {
    string      nm;
    logic [11:0] v;
    bit         in_rst;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .is_load    (is_load),
    .is_store   (is_store),
    .reg_we     (reg_we),
    .is_halt    (is_halt),
    .dec_illegal(dec_illegal),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir_we      (ir_we),
    .ex_we      (ex_we),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .halted     (halted),
    .trap       (trap),
    .state      (state)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  // Monitor: one expected entry per cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [11:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {state, imem_req, dmem_req, dmem_we, ir_we, ex_we, rf_we, pc_we, halted, trap};
      n_chk++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got state=%0d flags=%b, want state=%0d flags=%b",
                 e.nm, got[11:9], got[8:0], e.v[11:9], e.v[8:0]);
      end
`ifdef CTRL_PERF_CNT_EN
      if (e.in_rst) begin
        m_cyc = '0;
        m_ret = '0;
      end
      n_chk++;
      if (cycle_cnt !== m_cyc || instret_cnt !== m_ret) begin
        n_fail++;
        $display("FAIL %s perf: got cyc=%0d ret=%0d, want cyc=%0d ret=%0d",
                 e.nm, cycle_cnt, instret_cnt, m_cyc, m_ret);
      end
      if (e.v[11:9] != CTRL_IDLE && e.v[11:9] != CTRL_HALT && e.v[11:9] != CTRL_TRAP) begin
        m_cyc = m_cyc + 32'd1;
      end
      if (e.v[11:9] == CTRL_WB) begin
        m_ret = m_ret + 32'd1;
      end
`endif
    end
  end

  task automatic push(input string nm, input logic [2:0] st, input logic [8:0] fl,
                      input bit r);
    exp_t e;
    e.nm     = nm;
    e.v      = {st, fl};
    e.in_rst = r;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's acks and record what the DUT must show in that cycle.
  task automatic cyc(input string nm, input logic ia, input logic da, input logic [2:0] st,
                     input logic [8:0] fl);
    @(posedge clk);
    #1;
    imem_ack = ia;
    dmem_ack = da;
    push(nm, st, fl, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    push("reset", CTRL_IDLE, NONE, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("idle_after_reset", CTRL_IDLE, NONE, 1'b0);
  endtask

  task automatic set_dec(input logic l, input logic s, input logic w, input logic h,
                         input logic ill);
    is_load     = l;
    is_store    = s;
    reg_we      = w;
    is_halt     = h;
    dec_illegal = ill;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    do_reset();

    // ADD, zero-wait fetch: 1,2,3,5
    cyc("add_fetch", 1, 0, CTRL_FETCH, IREQ | IRWE);
    set_dec(0, 0, 1, 0, 0);
    cyc("add_decode", 0, 0, CTRL_DECODE, NONE);
    cyc("add_exec", 0, 0, CTRL_EXEC, EXWE);
    cyc("add_wb", 0, 0, CTRL_WB, RFWE | PCWE);

    // LW, dmem_ack on 4th MEM cycle (same cycle watchdog would fire); stray imem_ack in MEM
    cyc("lw_fetch", 1, 0, CTRL_FETCH, IREQ | IRWE);
    set_dec(1, 0, 1, 0, 0);
    cyc("lw_decode", 0, 0, CTRL_DECODE, NONE);
    cyc("lw_exec", 0, 0, CTRL_EXEC, EXWE);
    cyc("lw_mem0", 0, 0, CTRL_MEM, DREQ);
    cyc("lw_mem1", 1, 0, CTRL_MEM, DREQ);
    cyc("lw_mem2", 0, 0, CTRL_MEM, DREQ);
    cyc("lw_mem3_ack", 0, 1, CTRL_MEM, DREQ);
    cyc("lw_wb", 0, 0, CTRL_WB, RFWE | PCWE);

    // SW with one fetch wait; stray dmem_ack in DECODE ignored
    cyc("sw_fetch_wait", 0, 0, CTRL_FETCH, IREQ);
    cyc("sw_fetch_ack", 1, 0, CTRL_FETCH, IREQ | IRWE);
    set_dec(0, 1, 0, 0, 0);
    cyc("sw_decode", 0, 1, CTRL_DECODE, NONE);
    cyc("sw_exec", 0, 0, CTRL_EXEC, EXWE);
    cyc("sw_mem0", 0, 0, CTRL_MEM, DREQ | DWE);
    cyc("sw_mem1_ack", 0, 1, CTRL_MEM, DREQ | DWE);
    cyc("sw_wb", 0, 0, CTRL_WB, PCWE);

    // Load with no dmem_ack: TRAP after 4 wait cycles, sticky
    cyc("to_fetch", 1, 0, CTRL_FETCH, IREQ | IRWE);
    set_dec(1, 0, 1, 0, 0);
    cyc("to_decode", 0, 0, CTRL_DECODE, NONE);
    cyc("to_exec", 0, 0, CTRL_EXEC, EXWE);
    for (int i = 0; i < 4; i++) cyc("to_mem_wait", 0, 0, CTRL_MEM, DREQ);
    cyc("to_trap0", 0, 1, CTRL_TRAP, TRP);
    cyc("to_trap1", 1, 0, CTRL_TRAP, TRP);
    cyc("to_trap2", 0, 0, CTRL_TRAP, TRP);

    // Halt: sticky, acks ignored for 100 cycles
    do_reset();
    cyc("ht_fetch", 1, 0, CTRL_FETCH, IREQ | IRWE);
    set_dec(0, 0, 0, 1, 0);
    cyc("ht_decode", 0, 0, CTRL_DECODE, NONE);
    for (int i = 0; i < 100; i++) begin
      cyc("ht_halt", (i % 7) == 0, (i % 11) == 3, CTRL_HALT, HLT);
    end

    // Illegal beats halt
    do_reset();
    cyc("il_fetch", 1, 0, CTRL_FETCH, IREQ | IRWE);
    set_dec(0, 0, 1, 1, 1);
    cyc("il_decode", 0, 0, CTRL_DECODE, NONE);
    cyc("il_trap", 0, 0, CTRL_TRAP, TRP);
    cyc("il_trap_sticky", 1, 0, CTRL_TRAP, TRP);

    // Fetch timeout
    do_reset();
    set_dec(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc("ft_wait", 0, 0, CTRL_FETCH, IREQ);
    cyc("ft_trap", 1, 0, CTRL_TRAP, TRP);

    // Reset mid-MEM: request drops at once, then IDLE -> FETCH
    do_reset();
    cyc("rm_fetch", 1, 0, CTRL_FETCH, IREQ | IRWE);
    set_dec(1, 0, 1, 0, 0);
    cyc("rm_decode", 0, 0, CTRL_DECODE, NONE);
    cyc("rm_exec", 0, 0, CTRL_EXEC, EXWE);
    cyc("rm_mem0", 0, 0, CTRL_MEM, DREQ);
    do_reset();
    cyc("rm_fetch_again", 0, 0, CTRL_FETCH, IREQ);

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
